// File: rtl/gba_bus_pkg.sv
// -----------------------------------------------------------------------------
// gba_bus_pkg
//   Shared types and constants for the GBA cartridge ROM bus controller.
//   - GBA_ADDR_W / GBA_DATA_W : halfword address and data widths of the GBA bus
//   - hw_addr_t / hw_data_t   : halfword address / data types
//   - state_t                 : ROM bus sequencer states
//   - hw_addr_inc()           : halfword address increment, wraps at 2^24
// -----------------------------------------------------------------------------
package gba_bus_pkg;

    localparam int GBA_ADDR_W = 24;
    localparam int GBA_DATA_W = 16;

    typedef logic [GBA_ADDR_W-1:0] hw_addr_t;
    typedef logic [GBA_DATA_W-1:0] hw_data_t;

    typedef enum logic [2:0] {
        IDLE,   // no ROM transaction in progress
        REQ,    // read request presented to memory
        WAIT,   // read accepted, waiting for the response
        READY,  // prefetched halfword held in data_q
        WREQ,   // posted write presented to memory
        DRAIN   // transaction ended early, flushing the outstanding access
    } state_t;

    // The GBA bus counter wraps naturally at 2^24 halfwords.
    function automatic hw_addr_t hw_addr_inc(input hw_addr_t a);
        return a + hw_addr_t'(1);
    endfunction

endpackage

// File: rtl/gba_sync_edge.sv
// -----------------------------------------------------------------------------
// gba_sync_edge
//   Multi-flop synchronizer for one active-low GBA strobe, followed by a
//   previous-value register used for edge detection. Everything resets to 1
//   (strobe inactive) so no spurious edge appears when reset is released.
//   Ports:
//     clk, rst_n : system clock, asynchronous active-low reset
//     sig_i      : raw asynchronous strobe from the pad
//     sync_o     : synchronized strobe level
//     fall_o     : one-cycle pulse on a synchronized 1->0 transition
//     rise_o     : one-cycle pulse on a synchronized 0->1 transition
// -----------------------------------------------------------------------------
module gba_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic sync_o,
    output logic fall_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES:0]   shift_d;
    logic              prev_q;

    // Widened by one so the shift works for any STAGES >= 1.
    assign shift_d = {sync_q, sig_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // value of its neighbour, which is what makes this a shift chain.
            sync_q <= shift_d[STAGES-1:0];
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign fall_o = prev_q & ~sync_q[STAGES-1];
    assign rise_o = ~prev_q & sync_q[STAGES-1];

endmodule

// File: rtl/gba_rom_ctrl.sv
// -----------------------------------------------------------------------------
// gba_rom_ctrl
//   GBA cartridge ROM bus sequencer. Latches the 24-bit halfword address on
//   nCS fall, prefetches the addressed halfword over a valid/ready memory port,
//   drives it onto AD while nRD is low and auto-increments on every nRD rise.
//   nWR strobes (WRITE_EN=1) issue posted writes at the current address.
//   Ports:
//     clock, reset            : system clock, asynchronous active-low reset
//     gba_nCS/nRD/nWR         : GBA strobes (active low, asynchronous)
//     gba_AD_in, gba_A_in     : AD[15:0] and A[7:0] (address 23:16) pad inputs
//     gba_AD_out, gba_AD_oe   : AD pad output data and output enable
//     gba_A_oe                : A pad output enable, always 0
//     mem_req_*               : request channel (valid/ready, write, addr, wdata)
//     mem_rsp_valid/data      : in-order read responses, one per accepted read
//     status_underrun         : sticky flag, data requested before it was ready
//     status_clear            : clears status_underrun (set wins)
// -----------------------------------------------------------------------------
module gba_rom_ctrl
    import gba_bus_pkg::*;
#(
    parameter int ADDR_W      = GBA_ADDR_W,
    parameter int SYNC_STAGES = 2,
    parameter int WRITE_EN    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gba_nCS,
    input  logic              gba_nRD,
    input  logic              gba_nWR,
    input  logic [15:0]       gba_AD_in,
    input  logic [7:0]        gba_A_in,
    output logic [15:0]       gba_AD_out,
    output logic              gba_AD_oe,
    output logic              gba_A_oe,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [15:0]       mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [15:0]       mem_rsp_data,
    output logic              status_underrun,
    input  logic              status_clear
);

    localparam bit WR_ON = (WRITE_EN != 0);

    // -------------------------------------------------------------------------
    // Input synchronization and edge detection
    // -------------------------------------------------------------------------
    logic cs_s, cs_fall, cs_rise;
    logic rd_s, rd_fall, rd_rise;
    logic wr_s, wr_fall, wr_rise;

    gba_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk    (clock),
        .rst_n  (reset),
        .sig_i  (gba_nCS),
        .sync_o (cs_s),
        .fall_o (cs_fall),
        .rise_o (cs_rise)
    );

    gba_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rd (
        .clk    (clock),
        .rst_n  (reset),
        .sig_i  (gba_nRD),
        .sync_o (rd_s),
        .fall_o (rd_fall),
        .rise_o (rd_rise)
    );

    gba_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wr (
        .clk    (clock),
        .rst_n  (reset),
        .sig_i  (gba_nWR),
        .sync_o (wr_s),
        .fall_o (wr_fall),
        .rise_o (wr_rise)
    );

    // Only the nWR rising edge carries meaning; level and fall are spare.
    logic unused_wr;
    assign unused_wr = wr_s ^ wr_fall;

    // The bus goes through the same number of flops as the strobes, so the
    // value seen with an edge is the value the pins had when that edge arrived.
    logic [SYNC_STAGES-1:0][23:0] bus_q;
    logic [SYNC_STAGES:0][23:0]   bus_shift;
    logic [23:0]                  bus_s;
    logic [15:0]                  ad_s;
    logic [ADDR_W-1:0]            bus_addr;

    assign bus_shift = {bus_q, gba_A_in, gba_AD_in};
    assign bus_s     = bus_q[SYNC_STAGES-1];
    assign ad_s      = bus_s[15:0];
    assign bus_addr  = ADDR_W'(bus_s);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_q <= '0;
        end else begin
            bus_q <= bus_shift[SYNC_STAGES-1:0];
        end
    end

    logic wr_ev;
    assign wr_ev = WR_ON && wr_rise;

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_inc;
    logic [15:0]       data_q, data_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_valid_q, pend_valid_d;
    logic              drain_held_q, drain_held_d;   // request still awaiting ready
    logic              drain_write_q, drain_write_d; // held request is a write
    logic              drain_owed_q, drain_owed_d;   // read response still to discard
    logic              oe_q;
    logic              underrun_q;
    logic              underrun_set;

    assign addr_inc = addr_q + ADDR_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            wdata_q       <= '0;
            pend_addr_q   <= '0;
            pend_valid_q  <= 1'b0;
            drain_held_q  <= 1'b0;
            drain_write_q <= 1'b0;
            drain_owed_q  <= 1'b0;
            oe_q          <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            wdata_q       <= wdata_d;
            pend_addr_q   <= pend_addr_d;
            pend_valid_q  <= pend_valid_d;
            drain_held_q  <= drain_held_d;
            drain_write_q <= drain_write_d;
            drain_owed_q  <= drain_owed_d;
            oe_q          <= !cs_s && !rd_s;
            if (underrun_set) begin
                underrun_q <= 1'b1;
            end else if (status_clear) begin
                underrun_q <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every next-state value starts as a copy of its register, so a
        // branch that does not mention a signal holds it instead of making a latch.
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        wdata_d       = wdata_q;
        pend_addr_d   = pend_addr_q;
        pend_valid_d  = pend_valid_q;
        drain_held_d  = drain_held_q;
        drain_write_d = drain_write_q;
        drain_owed_d  = drain_owed_q;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    addr_d  = bus_addr;
                    state_d = REQ;
                end
            end

            REQ: begin
                // A cs_fall here cannot follow a proper cs_rise; it is handled
                // as an abort plus a fresh start so the held request stays legal.
                if (cs_rise || cs_fall) begin
                    state_d       = DRAIN;
                    drain_held_d  = !mem_req_ready;
                    drain_write_d = 1'b0;
                    drain_owed_d  = mem_req_ready;
                    pend_valid_d  = cs_fall;
                    pend_addr_d   = bus_addr;
                end else if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (mem_rsp_valid) begin
                    data_d = mem_rsp_data;
                    if (cs_fall) begin
                        addr_d  = bus_addr;
                        state_d = REQ;
                    end else if (cs_rise) begin
                        state_d = IDLE;
                    end else begin
                        state_d = READY;
                    end
                end else if (cs_rise || cs_fall) begin
                    state_d       = DRAIN;
                    drain_held_d  = 1'b0;
                    drain_write_d = 1'b0;
                    drain_owed_d  = 1'b1;
                    pend_valid_d  = cs_fall;
                    pend_addr_d   = bus_addr;
                end
            end

            READY: begin
                if (cs_fall) begin
                    addr_d  = bus_addr;
                    state_d = REQ;
                end else if (rd_rise) begin
                    // The increment is kept even when nCS rises in the same cycle.
                    addr_d  = addr_inc;
                    state_d = cs_rise ? IDLE : REQ;
                end else if (wr_ev) begin
                    wdata_d = ad_s;
                    if (cs_rise) begin
                        state_d       = DRAIN;
                        drain_held_d  = 1'b1;
                        drain_write_d = 1'b1;
                        drain_owed_d  = 1'b0;
                        pend_valid_d  = 1'b0;
                    end else begin
                        state_d = WREQ;
                    end
                end else if (cs_rise) begin
                    state_d = IDLE;
                end
            end

            WREQ: begin
                if (mem_req_ready) begin
                    if (cs_fall) begin
                        addr_d  = bus_addr;
                        state_d = REQ;
                    end else begin
                        addr_d  = addr_inc;
                        state_d = cs_rise ? IDLE : REQ;
                    end
                end else if (cs_rise || cs_fall) begin
                    state_d       = DRAIN;
                    drain_held_d  = 1'b1;
                    drain_write_d = 1'b1;
                    drain_owed_d  = 1'b0;
                    pend_valid_d  = cs_fall;
                    pend_addr_d   = bus_addr;
                end
            end

            DRAIN: begin
                if (cs_fall) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = bus_addr;
                end else if (cs_rise) begin
                    pend_valid_d = 1'b0;
                end

                if (drain_held_q) begin
                    if (mem_req_ready) begin
                        drain_held_d = 1'b0;
                        drain_owed_d = !drain_write_q;
                    end
                end else if (drain_owed_q) begin
                    if (mem_rsp_valid) begin
                        drain_owed_d = 1'b0;
                    end
                end else begin
                    pend_valid_d = 1'b0;
                    if (cs_fall) begin
                        addr_d  = bus_addr;
                        state_d = REQ;
                    end else if (pend_valid_q && !cs_rise) begin
                        addr_d  = pend_addr_q;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data is only guaranteed fresh in READY; anything else means stale AD.
    assign underrun_set = (state_q != READY) && (rd_fall || wr_ev);

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_req_valid   = (state_q == REQ) || (state_q == WREQ) ||
                             ((state_q == DRAIN) && drain_held_q);
    assign mem_req_write   = (state_q == WREQ) ||
                             ((state_q == DRAIN) && drain_held_q && drain_write_q);
    assign mem_req_addr    = addr_q;
    assign mem_req_wdata   = wdata_q;
    assign gba_AD_out      = data_q;
    assign gba_AD_oe       = oe_q;
    assign gba_A_oe        = 1'b0;
    assign status_underrun = underrun_q;

endmodule

// File: tb/tb_gba_rom_ctrl.sv
module tb_gba_rom_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        gba_nCS = 1'b1;
    logic        gba_nRD = 1'b1;
    logic        gba_nWR = 1'b1;
    logic [15:0] gba_AD_in = '0;
    logic [7:0]  gba_A_in = '0;
    logic [15:0] gba_AD_out;
    logic        gba_AD_oe;
    logic        gba_A_oe;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [23:0] mem_req_addr;
    logic [15:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;
    logic        status_underrun;
    logic        status_clear = 1'b0;

    int checks = 0;
    int failures = 0;

    // Memory model knobs and request log
    int          ready_delay = 0;
    int          rsp_delay = 3;
    logic        rsp_fixed_en = 1'b0;
    logic [15:0] rsp_fixed = '0;
    logic [23:0] log_addr[$];
    logic        log_write[$];
    logic [15:0] log_wdata[$];

    gba_rom_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .gba_nCS         (gba_nCS),
        .gba_nRD         (gba_nRD),
        .gba_nWR         (gba_nWR),
        .gba_AD_in       (gba_AD_in),
        .gba_A_in        (gba_A_in),
        .gba_AD_out      (gba_AD_out),
        .gba_AD_oe       (gba_AD_oe),
        .gba_A_oe        (gba_A_oe),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .status_underrun (status_underrun),
        .status_clear    (status_clear)
    );

    always #5 clock = ~clock;

    // Backing memory: ready pulses one cycle after ready_delay waiting cycles,
    // reads answer rsp_delay cycles after acceptance with addr[15:0] (or a
    // fixed value). Reset by the same reset as the DUT.
    initial begin
        int rdy_cnt;
        int rsp_cnt;
        logic [15:0] rsp_value;
        rdy_cnt = 0;
        rsp_cnt = 0;
        rsp_value = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        forever begin
            @(negedge clock);
            mem_rsp_valid = 1'b0;
            if (!reset) begin
                mem_req_ready = 1'b0;
                rdy_cnt = 0;
                rsp_cnt = 0;
            end else begin
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data = rsp_value;
                    end
                end
                if (mem_req_ready) begin
                    mem_req_ready = 1'b0;
                end else if (mem_req_valid) begin
                    if (rdy_cnt >= ready_delay) begin
                        mem_req_ready = 1'b1;
                        rdy_cnt = 0;
                        log_addr.push_back(mem_req_addr);
                        log_write.push_back(mem_req_write);
                        log_wdata.push_back(mem_req_wdata);
                        if (!mem_req_write) begin
                            rsp_cnt = rsp_delay;
                            rsp_value = rsp_fixed_en ? rsp_fixed : mem_req_addr[15:0];
                        end
                    end else begin
                        rdy_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_write.delete();
        log_wdata.delete();
    endtask

    task automatic cs_start(input logic [23:0] addr);
        @(negedge clock);
        gba_A_in = addr[23:16];
        gba_AD_in = addr[15:0];
        gba_nCS = 1'b0;
        cycles(4);
        gba_AD_in = '0;
        gba_A_in = '0;
    endtask

    task automatic cs_end();
        cycles(12);
        gba_nCS = 1'b1;
        cycles(12);
    endtask

    task automatic rd_low();
        gba_nRD = 1'b0;
        cycles(5);
    endtask

    task automatic rd_high();
        gba_nRD = 1'b1;
        cycles(10);
    endtask

    task automatic wait_req(input int n, input string name);
        int cyc;
        cyc = 0;
        while (log_addr.size() < n && cyc < 200) begin
            cycles(1);
            cyc++;
        end
        if (log_addr.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d requests, expected %0d", name, log_addr.size(), n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cycles(3);
        checks++; if (gba_AD_out !== 16'h0000) begin failures++; $display("FAIL reset_ad_out: got %h expected 0000", gba_AD_out); end
        checks++; if (gba_AD_oe !== 1'b0) begin failures++; $display("FAIL reset_ad_oe: got %b expected 0", gba_AD_oe); end
        checks++; if (gba_A_oe !== 1'b0) begin failures++; $display("FAIL reset_a_oe: got %b expected 0", gba_A_oe); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", mem_req_valid); end
        checks++; if (mem_req_write !== 1'b0) begin failures++; $display("FAIL reset_write: got %b expected 0", mem_req_write); end
        checks++; if (mem_req_addr !== 24'h000000) begin failures++; $display("FAIL reset_addr: got %h expected 000000", mem_req_addr); end
        checks++; if (mem_req_wdata !== 16'h0000) begin failures++; $display("FAIL reset_wdata: got %h expected 0000", mem_req_wdata); end
        checks++; if (status_underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b expected 0", status_underrun); end
        reset = 1'b1;
        cycles(4);
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL idle_valid: got %b expected 0", mem_req_valid); end
    endtask

    task automatic test_single_read();
        clear_log();
        rsp_fixed_en = 1'b1;
        rsp_fixed = 16'hBEEF;
        cs_start(24'h123456);
        wait_req(1, "single");
        checks++; if (log_addr[0] !== 24'h123456) begin failures++; $display("FAIL single_addr: got %h expected 123456", log_addr[0]); end
        checks++; if (log_write[0] !== 1'b0) begin failures++; $display("FAIL single_write: got %b expected 0", log_write[0]); end
        cycles(8);
        rd_low();
        checks++; if (gba_AD_oe !== 1'b1) begin failures++; $display("FAIL single_oe: got %b expected 1", gba_AD_oe); end
        checks++; if (gba_AD_out !== 16'hBEEF) begin failures++; $display("FAIL single_data: got %h expected beef", gba_AD_out); end
        checks++; if (status_underrun !== 1'b0) begin failures++; $display("FAIL single_underrun: got %b expected 0", status_underrun); end
        rd_high();
        checks++; if (gba_AD_oe !== 1'b0) begin failures++; $display("FAIL single_oe_off: got %b expected 0", gba_AD_oe); end
        cs_end();
        rsp_fixed_en = 1'b0;
    endtask

    task automatic test_burst();
        logic [15:0] exp16;
        logic [23:0] exp24;
        clear_log();
        cs_start(24'h000010);
        cycles(8);
        for (int i = 0; i < 4; i++) begin
            exp16 = 16'h0010 + 16'(i);
            rd_low();
            checks++; if (gba_AD_out !== exp16) begin failures++; $display("FAIL burst_data%0d: got %h expected %h", i, gba_AD_out, exp16); end
            rd_high();
        end
        wait_req(5, "burst");
        for (int i = 0; i < 5; i++) begin
            exp24 = 24'h000010 + 24'(i);
            checks++; if (log_addr[i] !== exp24) begin failures++; $display("FAIL burst_addr%0d: got %h expected %h", i, log_addr[i], exp24); end
        end
        cs_end();
    endtask

    task automatic test_wrap();
        clear_log();
        cs_start(24'hFFFFFF);
        cycles(8);
        rd_low();
        checks++; if (gba_AD_out !== 16'hFFFF) begin failures++; $display("FAIL wrap_data0: got %h expected ffff", gba_AD_out); end
        rd_high();
        rd_low();
        checks++; if (gba_AD_out !== 16'h0000) begin failures++; $display("FAIL wrap_data1: got %h expected 0000", gba_AD_out); end
        rd_high();
        wait_req(3, "wrap");
        checks++; if (log_addr[1] !== 24'h000000) begin failures++; $display("FAIL wrap_addr1: got %h expected 000000", log_addr[1]); end
        checks++; if (log_addr[2] !== 24'h000001) begin failures++; $display("FAIL wrap_addr2: got %h expected 000001", log_addr[2]); end
        cs_end();
    endtask

    task automatic test_underrun();
        clear_log();
        ready_delay = 20;
        cs_start(24'h000040);
        rd_low();
        checks++; if (status_underrun !== 1'b1) begin failures++; $display("FAIL underrun_set: got %b expected 1", status_underrun); end
        checks++; if (gba_AD_out !== 16'h0001) begin failures++; $display("FAIL underrun_stale: got %h expected 0001", gba_AD_out); end
        rd_high();
        checks++; if (status_underrun !== 1'b1) begin failures++; $display("FAIL underrun_sticky: got %b expected 1", status_underrun); end
        status_clear = 1'b1;
        cycles(1);
        status_clear = 1'b0;
        checks++; if (status_underrun !== 1'b0) begin failures++; $display("FAIL underrun_clear: got %b expected 0", status_underrun); end
        wait_req(1, "underrun");
        cycles(8);
        rd_low();
        checks++; if (gba_AD_out !== 16'h0040) begin failures++; $display("FAIL underrun_data: got %h expected 0040", gba_AD_out); end
        checks++; if (status_underrun !== 1'b0) begin failures++; $display("FAIL underrun_quiet: got %b expected 0", status_underrun); end
        ready_delay = 0;
        rd_high();
        cs_end();
    endtask

    task automatic test_abort();
        clear_log();
        rsp_delay = 10;
        cs_start(24'h000300);
        wait_req(1, "abort_first");
        gba_nCS = 1'b1;
        cycles(3);
        cs_start(24'h000200);
        wait_req(2, "abort_second");
        cycles(16);
        checks++; if (log_addr.size() !== 2) begin failures++; $display("FAIL abort_count: got %0d expected 2", log_addr.size()); end
        checks++; if (log_addr[1] !== 24'h000200) begin failures++; $display("FAIL abort_addr: got %h expected 000200", log_addr[1]); end
        rsp_delay = 3;
        rd_low();
        checks++; if (gba_AD_out !== 16'h0200) begin failures++; $display("FAIL abort_data: got %h expected 0200", gba_AD_out); end
        checks++; if (status_underrun !== 1'b0) begin failures++; $display("FAIL abort_underrun: got %b expected 0", status_underrun); end
        rd_high();
        cs_end();
    endtask

    task automatic test_write();
        clear_log();
        cs_start(24'h000100);
        cycles(8);
        gba_AD_in = 16'hA5A5;
        gba_nWR = 1'b0;
        cycles(5);
        checks++; if (gba_AD_oe !== 1'b0) begin failures++; $display("FAIL write_oe: got %b expected 0", gba_AD_oe); end
        gba_nWR = 1'b1;
        cycles(3);
        gba_AD_in = '0;
        wait_req(3, "write");
        checks++; if (log_write[1] !== 1'b1) begin failures++; $display("FAIL write_kind: got %b expected 1", log_write[1]); end
        checks++; if (log_addr[1] !== 24'h000100) begin failures++; $display("FAIL write_addr: got %h expected 000100", log_addr[1]); end
        checks++; if (log_wdata[1] !== 16'hA5A5) begin failures++; $display("FAIL write_wdata: got %h expected a5a5", log_wdata[1]); end
        checks++; if (log_write[2] !== 1'b0) begin failures++; $display("FAIL write_next_kind: got %b expected 0", log_write[2]); end
        checks++; if (log_addr[2] !== 24'h000101) begin failures++; $display("FAIL write_next_addr: got %h expected 000101", log_addr[2]); end
        checks++; if (status_underrun !== 1'b0) begin failures++; $display("FAIL write_underrun: got %b expected 0", status_underrun); end
        cs_end();
    endtask

    task automatic test_reset_mid();
        clear_log();
        ready_delay = 30;
        cs_start(24'h000555);
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL rstmid_valid_before: got %b expected 1", mem_req_valid); end
        checks++; if (mem_req_addr !== 24'h000555) begin failures++; $display("FAIL rstmid_addr_before: got %h expected 000555", mem_req_addr); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", mem_req_valid); end
        checks++; if (mem_req_addr !== 24'h000000) begin failures++; $display("FAIL rstmid_addr: got %h expected 000000", mem_req_addr); end
        checks++; if (gba_AD_out !== 16'h0000) begin failures++; $display("FAIL rstmid_ad_out: got %h expected 0000", gba_AD_out); end
        checks++; if (gba_AD_oe !== 1'b0) begin failures++; $display("FAIL rstmid_oe: got %b expected 0", gba_AD_oe); end
        checks++; if (mem_req_write !== 1'b0) begin failures++; $display("FAIL rstmid_write: got %b expected 0", mem_req_write); end
        gba_nCS = 1'b1;
        cycles(3);
        reset = 1'b1;
        ready_delay = 0;
        cycles(5);
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got %b expected 0", mem_req_valid); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst();
        test_wrap();
        test_underrun();
        test_abort();
        test_write();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
